fp_add_norm_round: RTL and testbench

- Sequential back-end for the single-precision adder.
- Consumes the raw, exponent-aligned sum produced by the add/subtract core.
- Normalises it iteratively, one left shift per cycle, then rounds round-to-nearest-even.
- Packs the IEEE-754 binary32 result behind a valid/ready handshake, replacing the combinational normalise/pack path.

---
 rtl/fp32_pkg.sv | 11 +
 rtl/fp_rne_round.sv | 20 ++
 rtl/fp_add_norm_round.sv | 104 ++++++++++
 tb/tb_fp_add_norm_round.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 widths, constants and back-end state encoding
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: round-to-nearest-even of a normalised hidden.fraction.GRS mantissa
module fp_rne_round
    import fp32_pkg::*;
(
    input  logic [MANT_W-2:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_ovf
);
    logic              w_inc;
    logic [FRAC_W+1:0] w_sum;
    logic [EXP_W:0]    w_exp;
    assign w_inc  = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
    assign w_sum  = {1'b0, i_mant[FRAC_W+3:3]} + (FRAC_W+2)'(w_inc);
    assign w_exp  = {1'b0, i_exp} + (EXP_W+1)'(w_sum[FRAC_W+1]);
    assign o_frac = w_sum[FRAC_W+1] ? '0 : w_sum[FRAC_W-1:0];
    assign o_exp  = w_exp[EXP_W-1:0];
    assign o_ovf  = w_exp >= (EXP_W+1)'(EXP_MAX);
endmodule

// File: rtl/fp_add_norm_round.sv
// fp_add_norm_round: iterative normalise, RNE round and pack of an aligned adder sum
module fp_add_norm_round
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_special,
    input  logic [31:0]       in_special_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_ovf,
    output logic              out_unf
);
    state_t              r_state;
    logic                r_sign;
    logic [EXP_W-1:0]    r_exp;
    logic [MANT_W-1:0]   r_mant;
    logic [31:0]         r_result;
    logic                r_ovf;
    logic                r_unf;
    logic [EXP_W:0]      w_exp_inc;
    logic [FRAC_W-1:0]   w_rnd_frac;
    logic [EXP_W-1:0]    w_rnd_exp;
    logic                w_rnd_ovf;
    assign w_exp_inc  = {1'b0, in_exp} + (EXP_W+1)'(1);
    assign in_ready   = r_state == IDLE;
    assign out_valid  = r_state == DONE;
    assign out_result = r_result;
    assign out_ovf    = r_ovf;
    assign out_unf    = r_unf;
    fp_rne_round u_round (
        .i_mant (r_mant[MANT_W-2:0]),
        .i_exp  (r_exp),
        .o_frac (w_rnd_frac),
        .o_exp  (w_rnd_exp),
        .o_ovf  (w_rnd_ovf)
    );
    // Accept, normalise one bit per cycle, round, then hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign <= in_sign;
                    if (in_special) begin
                        r_result <= in_special_val;
                        r_state  <= DONE;
                    end else if (in_mant == '0) begin
                        r_result <= '0;
                        r_state  <= DONE;
                    end else if (in_mant[MANT_W-1]) begin
                        if (w_exp_inc >= (EXP_W+1)'(EXP_MAX)) begin
                            r_result <= {in_sign, POS_INF[30:0]};
                            r_ovf    <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_mant  <= {1'b0, in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
                            r_exp   <= w_exp_inc[EXP_W-1:0];
                            r_state <= NORM;
                        end
                    end else begin
                        r_mant  <= in_mant;
                        r_exp   <= in_exp;
                        r_state <= NORM;
                    end
                end
                NORM: if (r_mant[MANT_W-2]) begin
                    r_state <= ROUND;
                end else if (r_exp <= EXP_W'(1)) begin
                    r_result <= {r_sign, 31'b0};
                    r_unf    <= 1'b1;
                    r_state  <= DONE;
                end else begin
                    r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                    r_exp  <= r_exp - EXP_W'(1);
                end
                ROUND: begin
                    r_result <= w_rnd_ovf ? {r_sign, POS_INF[30:0]} : {r_sign, w_rnd_exp, w_rnd_frac};
                    r_ovf    <= w_rnd_ovf;
                    r_state  <= DONE;
                end
                DONE: if (out_ready) begin
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_norm_round.sv
// tb_fp_add_norm_round: directed vector table plus backpressure and mid-flight reset sequences
module tb_fp_add_norm_round;
    import fp32_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_special = 1'b0;
    logic [31:0] in_special_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        string       nm;
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic        sp;
        logic [31:0] sv;
        logic [31:0] r;
        logic        o;
        logic        u;
        int          lat;
    } vec_t;
    vec_t v[12];
    fp_add_norm_round dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_ovf        (out_ovf),
        .out_unf        (out_unf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask
    task automatic drive(input vec_t x);
        in_sign = x.s;
        in_exp = x.e;
        in_mant = x.m;
        in_special = x.sp;
        in_special_val = x.sv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic apply(input vec_t x, output int lat);
        drive(x);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic check_vec(input vec_t x);
        int lat;
        apply(x, lat);
        chk({x.nm, " latency"}, lat, x.lat);
        chk({x.nm, " result"}, out_result, x.r);
        chk({x.nm, " ovf"}, {31'b0, out_ovf}, {31'b0, x.o});
        chk({x.nm, " unf"}, {31'b0, out_unf}, {31'b0, x.u});
    endtask
    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " post valid"}, {31'b0, out_valid}, 32'd0);
        chk({nm, " post ready"}, {31'b0, in_ready}, 32'd1);
        chk({nm, " post flags"}, {30'b0, out_ovf, out_unf}, 32'd0);
    endtask
    initial begin
        v[0]  = '{"3+2",       1'b0, 8'd128, 28'hA000000, 1'b0, 32'h0, 32'h40A00000, 1'b0, 1'b0, 2};
        v[1]  = '{"cancel",    1'b1, 8'd130, 28'h0000000, 1'b0, 32'h0, 32'h00000000, 1'b0, 1'b0, 0};
        v[2]  = '{"max+max",   1'b0, 8'd254, 28'hFFFFFF8, 1'b0, 32'h0, 32'h7F800000, 1'b1, 1'b0, 0};
        v[3]  = '{"1-0.75",    1'b0, 8'd127, 28'h1000000, 1'b0, 32'h0, 32'h3E800000, 1'b0, 1'b0, 4};
        v[4]  = '{"special",   1'b1, 8'd3,   28'h4000000, 1'b1, QNAN,  QNAN,         1'b0, 1'b0, 0};
        v[5]  = '{"tie even",  1'b0, 8'd127, 28'h4000004, 1'b0, 32'h0, 32'h3F800000, 1'b0, 1'b0, 2};
        v[6]  = '{"tie odd",   1'b0, 8'd127, 28'h400000C, 1'b0, 32'h0, 32'h3F800002, 1'b0, 1'b0, 2};
        v[7]  = '{"all ones",  1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 32'h0, 32'h40000000, 1'b0, 1'b0, 2};
        v[8]  = '{"round ovf", 1'b1, 8'd254, 28'h7FFFFFC, 1'b0, 32'h0, 32'hFF800000, 1'b1, 1'b0, 2};
        v[9]  = '{"underflow", 1'b1, 8'd2,   28'h1000000, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b1, 2};
        v[10] = '{"above half",1'b1, 8'd127, 28'h4000006, 1'b0, 32'h0, 32'hBF800001, 1'b0, 1'b0, 2};
        v[11] = '{"carry stky",1'b0, 8'd127, 28'h8000009, 1'b0, 32'h0, 32'h40000001, 1'b0, 1'b0, 2};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset valid", {31'b0, out_valid}, 32'd0);
        chk("reset ready", {31'b0, in_ready}, 32'd1);
        chk("reset result", out_result, 32'd0);
        chk("reset flags", {30'b0, out_ovf, out_unf}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            check_vec(v[i]);
            release_out(v[i].nm);
        end
        check_vec(v[0]);
        in_sign = 1'b1;
        in_exp = 8'd10;
        in_mant = 28'h0000001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold result", out_result, 32'h40A00000);
            chk("hold valid", {31'b0, out_valid}, 32'd1);
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out("hold");
        drive(v[3]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst valid", {31'b0, out_valid}, 32'd0);
        chk("midrst result", out_result, 32'd0);
        chk("midrst ready", {31'b0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst idle", {31'b0, out_valid}, 32'd0);
        check_vec(v[0]);
        release_out("after rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
